// File: rtl/rsp_s2_prep_ahbic_pkg.sv
// rtl/rsp_s2_prep_ahbic_pkg.sv - shared AHB encodings and port-index types for the bus-matrix output stage
package rsp_s2_prep_ahbic_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_e;

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned PORT_W    = 2;

    typedef logic [PORT_W-1:0] port_idx_t;

    localparam port_idx_t  NO_PORT        = 2'd3;
    localparam port_idx_t  LAST_GRANT_RST = 2'd2;
    localparam logic [2:0] BURST_SINGLE   = 3'b000;
    localparam logic [2:0] BURST_INCR4    = 3'b011;

    // Port that is k positions after p in round-robin order.
    function automatic port_idx_t rr_next(input port_idx_t p, input int unsigned k);
        int unsigned s;
        s = (32'(p) + k) % NUM_PORTS;
        return port_idx_t'(s);
    endfunction

endpackage

// File: rtl/rsp_s2_prep_ahbic_arb_rr.sv
// rtl/rsp_s2_prep_ahbic_arb_rr.sv - combinational 3-way round-robin arbiter with hold
module rsp_s2_prep_ahbic_arb_rr
    import rsp_s2_prep_ahbic_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  port_idx_t            last_grant,
    input  logic                 hold,
    output port_idx_t            next_owner
);

    port_idx_t cand;
    logic      found;

    // While holding, the owner is always the last granted port.
    always_comb begin
        next_owner = NO_PORT;
        cand       = NO_PORT;
        found      = 1'b0;
        if (hold) begin
            next_owner = last_grant;
        end else begin
            for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
                cand = rr_next(last_grant, k);
                if (!found && req[cand]) begin
                    next_owner = cand;
                    found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsp_s2_prep_ahbic_out_stage.sv
// rtl/rsp_s2_prep_ahbic_out_stage.sv - AHB bus-matrix output stage: arbitrates three input stages onto one slave port
module rsp_s2_prep_ahbic_out_stage
    import rsp_s2_prep_ahbic_pkg::*;
#(
    parameter int NUM_SI = 3,
    parameter int AW     = 32,
    parameter int DW     = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,

    input  logic          sel_op_0,
    input  logic [AW-1:0] addr_op_0,
    input  logic [1:0]    trans_op_0,
    input  logic          write_op_0,
    input  logic [2:0]    size_op_0,
    input  logic [2:0]    burst_op_0,
    input  logic [3:0]    prot_op_0,
    input  logic          mastlock_op_0,
    input  logic [DW-1:0] wdata_op_0,
    output logic          active_op_0,

    input  logic          sel_op_1,
    input  logic [AW-1:0] addr_op_1,
    input  logic [1:0]    trans_op_1,
    input  logic          write_op_1,
    input  logic [2:0]    size_op_1,
    input  logic [2:0]    burst_op_1,
    input  logic [3:0]    prot_op_1,
    input  logic          mastlock_op_1,
    input  logic [DW-1:0] wdata_op_1,
    output logic          active_op_1,

    input  logic          sel_op_2,
    input  logic [AW-1:0] addr_op_2,
    input  logic [1:0]    trans_op_2,
    input  logic          write_op_2,
    input  logic [2:0]    size_op_2,
    input  logic [2:0]    burst_op_2,
    input  logic [3:0]    prot_op_2,
    input  logic          mastlock_op_2,
    input  logic [DW-1:0] wdata_op_2,
    output logic          active_op_2,

    output logic          readyout_op,
    output logic [1:0]    resp_op,
    output logic [DW-1:0] rdata_op,

    output logic          HSELM,
    output logic [AW-1:0] HADDRM,
    output logic [1:0]    HTRANSM,
    output logic          HWRITEM,
    output logic [2:0]    HSIZEM,
    output logic [2:0]    HBURSTM,
    output logic [3:0]    HPROTM,
    output logic          HMASTLOCKM,
    output logic [DW-1:0] HWDATAM,
    output logic          HREADYMUXM,
    input  logic          HREADYOUTM,
    input  logic [1:0]    HRESPM,
    input  logic [DW-1:0] HRDATAM
);

    logic          sel_a   [NUM_SI];
    logic [AW-1:0] addr_a  [NUM_SI];
    logic [1:0]    trans_a [NUM_SI];
    logic          write_a [NUM_SI];
    logic [2:0]    size_a  [NUM_SI];
    logic [2:0]    burst_a [NUM_SI];
    logic [3:0]    prot_a  [NUM_SI];
    logic          lock_a  [NUM_SI];
    logic [DW-1:0] wdata_a [NUM_SI];

    assign sel_a   = '{sel_op_0, sel_op_1, sel_op_2};
    assign addr_a  = '{addr_op_0, addr_op_1, addr_op_2};
    assign trans_a = '{trans_op_0, trans_op_1, trans_op_2};
    assign write_a = '{write_op_0, write_op_1, write_op_2};
    assign size_a  = '{size_op_0, size_op_1, size_op_2};
    assign burst_a = '{burst_op_0, burst_op_1, burst_op_2};
    assign prot_a  = '{prot_op_0, prot_op_1, prot_op_2};
    assign lock_a  = '{mastlock_op_0, mastlock_op_1, mastlock_op_2};
    assign wdata_a = '{wdata_op_0, wdata_op_1, wdata_op_2};

    port_idx_t         addr_in_port;
    port_idx_t         data_in_port;
    port_idx_t         last_grant;
    port_idx_t         next_owner;
    port_idx_t         owner;
    logic              hold;
    logic [NUM_SI-1:0] req;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_SI; i++) begin
            req[i] = sel_a[i] && (trans_a[i] != TRANS_IDLE);
        end
    end

    // A NONSEQ only keeps the grant when it opens a multi-beat burst.
    always_comb begin
        hold = 1'b0;
        for (int i = 0; i < NUM_SI; i++) begin
            if (addr_in_port == port_idx_t'(i)) begin
                hold = (trans_a[i] == TRANS_SEQ) || (trans_a[i] == TRANS_BUSY) || lock_a[i]
                    || ((trans_a[i] == TRANS_NONSEQ) && sel_a[i] && (burst_a[i] != BURST_SINGLE));
            end
        end
    end

    rsp_s2_prep_ahbic_arb_rr u_arb (
        .req        (req),
        .last_grant (last_grant),
        .hold       (hold),
        .next_owner (next_owner)
    );

    // Idle port: the fresh winner drives the bus in the same cycle, never while in reset.
    always_comb begin
        if (addr_in_port == NO_PORT) begin
            owner = (HREADYOUTM && HRESETn) ? next_owner : NO_PORT;
        end else begin
            owner = addr_in_port;
        end
    end

    assign active_op_0 = (owner == 2'd0);
    assign active_op_1 = (owner == 2'd1);
    assign active_op_2 = (owner == 2'd2);

    always_comb begin
        HSELM      = 1'b0;
        HADDRM     = '0;
        HTRANSM    = TRANS_IDLE;
        HWRITEM    = 1'b0;
        HSIZEM     = '0;
        HBURSTM    = '0;
        HPROTM     = '0;
        HMASTLOCKM = 1'b0;
        for (int i = 0; i < NUM_SI; i++) begin
            if (owner == port_idx_t'(i)) begin
                HSELM      = sel_a[i];
                HADDRM     = addr_a[i];
                HTRANSM    = trans_a[i];
                HWRITEM    = write_a[i];
                HSIZEM     = size_a[i];
                HBURSTM    = burst_a[i];
                HPROTM     = prot_a[i];
                HMASTLOCKM = lock_a[i];
            end
        end
    end

    always_comb begin
        HWDATAM = '0;
        for (int i = 0; i < NUM_SI; i++) begin
            if (data_in_port == port_idx_t'(i)) begin
                HWDATAM = wdata_a[i];
            end
        end
    end

    assign HREADYMUXM  = HREADYOUTM;
    assign readyout_op = HREADYOUTM;
    assign resp_op     = HRESPM;
    assign rdata_op    = HRDATAM;

    // A stalled slave freezes both the address and data phase ownership.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= NO_PORT;
            data_in_port <= NO_PORT;
            last_grant   <= LAST_GRANT_RST;
        end else if (HREADYOUTM) begin
            addr_in_port <= next_owner;
            data_in_port <= HSELM ? owner : NO_PORT;
            if (next_owner != NO_PORT) begin
                last_grant <= next_owner;
            end
        end
    end

endmodule
